// File: rtl/axi_stream_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter and its output stage.
package axi_stream_pkg;

    // Arbiter FSM: IDLE picks a winner, LOCKED carries one packet to its TLAST.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Widest request vector the priority picker is written for.
    localparam int MAX_SOURCES = 32;

    // Ceiling log2 for sizing index fields; valid for 1 <= value <= 2**30.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if (value > (1 << i)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Round-robin pick: first set bit of req at or above ptr, wrapping modulo n.
    // Scans from the far end so the nearest hit (smallest offset) wins.
    // Returns ptr when nothing is requested; callers only use it when req != 0.
    function automatic int rr_pick(input logic [MAX_SOURCES-1:0] req,
                                   input int ptr,
                                   input int n);
        int result;
        int idx;
        result = ptr;
        for (int k = MAX_SOURCES - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[4:0]]) begin
                    result = idx;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_stream_output_slice.sv
// Single-entry registered AXI-Stream output stage.
// Handshake: a beat transfers on any rising edge where valid and ready are both high;
// m_tvalid_o never drops and m_* never change while a beat waits for m_tready_i.
// ready_o tells the producer a beat offered on load_i will be taken this cycle.
module axi_stream_output_slice #(
    parameter int payload_width = 8,
    parameter int tid_width     = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     load_i,
    input  logic [payload_width-1:0] payload_i,
    input  logic                     tlast_i,
    input  logic [tid_width-1:0]     tid_i,
    output logic                     ready_o,
    output logic                     m_tvalid_o,
    input  logic                     m_tready_i,
    output logic [payload_width-1:0] m_payload_o,
    output logic                     m_tlast_o,
    output logic [tid_width-1:0]     m_tid_o
);

    logic                     valid_q, valid_d;
    logic [payload_width-1:0] payload_q, payload_d;
    logic                     tlast_q, tlast_d;
    logic [tid_width-1:0]     tid_q, tid_d;
    logic                     do_load;

    // Empty, or the held beat leaves this cycle: a new beat can enter.
    assign ready_o = !valid_q || m_tready_i;
    assign do_load = load_i && ready_o;

    // Next-state: load a new beat, otherwise drop valid once the held beat is taken.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        tlast_d   = tlast_q;
        tid_d     = tid_q;
        if (do_load) begin
            valid_d   = 1'b1;
            payload_d = payload_i;
            tlast_d   = tlast_i;
            tid_d     = tid_i;
        end else if (m_tready_i) begin
            valid_d = 1'b0;
        end
    end

    // Output register with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            tlast_q   <= 1'b0;
            tid_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            tlast_q   <= tlast_d;
            tid_q     <= tid_d;
        end
    end

    assign m_tvalid_o  = valid_q;
    assign m_payload_o = payload_q;
    assign m_tlast_o   = tlast_q;
    assign m_tid_o     = tid_q;

endmodule

// File: rtl/axi_stream_rr_arbiter.sv
// Packet-level round-robin merge of num_sources AXI-Stream inputs onto one registered output.
// A grant is taken in IDLE (one arbitration cycle) and held until the granted source's
// TLAST beat is accepted, so packets never interleave. m_tid names the winning source.
module axi_stream_rr_arbiter
    import axi_stream_pkg::*;
#(
    parameter int num_sources = 4,
    parameter int byte_width  = 4,
    parameter int user_width  = 1
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [num_sources-1:0]              s_tvalid,
    output logic [num_sources-1:0]              s_tready,
    input  logic [num_sources*8*byte_width-1:0] s_tdata,
    input  logic [num_sources*byte_width-1:0]   s_tkeep,
    input  logic [num_sources*byte_width-1:0]   s_tstrb,
    input  logic [num_sources-1:0]              s_tlast,
    input  logic [num_sources*user_width-1:0]   s_tuser,
    output logic                                m_tvalid,
    input  logic                                m_tready,
    output logic [8*byte_width-1:0]             m_tdata,
    output logic [byte_width-1:0]               m_tkeep,
    output logic [byte_width-1:0]               m_tstrb,
    output logic                                m_tlast,
    output logic [user_width-1:0]               m_tuser,
    output logic [clog2(num_sources)-1:0]       m_tid,
    output logic [15:0]                         pkt_count,
    output logic                                dbg_state
);

    localparam int idx_w     = clog2(num_sources);
    localparam int data_w    = 8 * byte_width;
    localparam int payload_w = data_w + 2 * byte_width + user_width;

    arb_state_e             state_q, state_d;
    logic [idx_w-1:0]       grant_q, grant_d;
    logic [idx_w-1:0]       ptr_q, ptr_d;
    logic [idx_w-1:0]       pick_idx;
    logic [15:0]            pkt_count_q, pkt_count_d;
    logic [MAX_SOURCES-1:0] req_pad;
    logic                   slice_ready;
    logic                   sel_valid;
    logic                   sel_last;
    logic [payload_w-1:0]   sel_payload;
    logic [payload_w-1:0]   m_payload;
    logic                   accept;

    // Widen the request vector for the shared picker and choose the next winner.
    always_comb begin
        req_pad                  = '0;
        req_pad[num_sources-1:0] = s_tvalid;
        pick_idx                 = idx_w'(rr_pick(req_pad, int'(ptr_q), num_sources));
    end

    // Input mux: route the granted source's beat toward the output stage.
    always_comb begin
        sel_valid   = 1'b0;
        sel_last    = 1'b0;
        sel_payload = '0;
        for (int i = 0; i < num_sources; i++) begin
            if (grant_q == idx_w'(i)) begin
                sel_valid   = s_tvalid[i];
                sel_last    = s_tlast[i];
                sel_payload = {s_tdata[i*data_w +: data_w],
                               s_tkeep[i*byte_width +: byte_width],
                               s_tstrb[i*byte_width +: byte_width],
                               s_tuser[i*user_width +: user_width]};
            end
        end
    end

    assign accept = (state_q == ST_LOCKED) && sel_valid && slice_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: lock on any request, release after the TLAST beat is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|s_tvalid) state_d = ST_LOCKED;
            ST_LOCKED: if (accept && sel_last) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: only the granted source sees TREADY, and only while LOCKED.
    always_comb begin
        s_tready = '0;
        if (state_q == ST_LOCKED) begin
            s_tready[grant_q] = slice_ready;
        end
    end

    // Grant is captured in IDLE; the pointer moves one past the source whose packet ended.
    always_comb begin
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if ((state_q == ST_IDLE) && (|s_tvalid)) begin
            grant_d = pick_idx;
        end
        if (accept && sel_last) begin
            ptr_d = (grant_q == idx_w'(num_sources - 1)) ? '0 : grant_q + idx_w'(1);
        end
    end

    // Grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Count packets as their TLAST beat leaves on the output; wraps naturally at 16 bits.
    always_comb begin
        pkt_count_d = pkt_count_q + 16'(m_tvalid && m_tready && m_tlast);
    end

    // Packet counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    axi_stream_output_slice #(
        .payload_width(payload_w),
        .tid_width    (idx_w)
    ) u_out_slice (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (accept),
        .payload_i  (sel_payload),
        .tlast_i    (sel_last),
        .tid_i      (grant_q),
        .ready_o    (slice_ready),
        .m_tvalid_o (m_tvalid),
        .m_tready_i (m_tready),
        .m_payload_o(m_payload),
        .m_tlast_o  (m_tlast),
        .m_tid_o    (m_tid)
    );

    assign {m_tdata, m_tkeep, m_tstrb, m_tuser} = m_payload;
    assign pkt_count = pkt_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Bench for axi_stream_rr_arbiter: directed scenarios plus a randomized phase.
// Sources are queue-driven; the model tracks packets per source and predicts the
// winner order from the rotation rule over sources that still have packets.
module tb_axi_stream_rr_arbiter;
  localparam int N = 4;
  localparam int BW = 4;
  localparam int UW = 1;
  localparam int DW = 32;
  localparam int BEAT_W = DW + 2 * BW + 1 + UW;  // {user, last, strb, keep, data}
  localparam int LAST_B = DW + 2 * BW;

  logic clk = 1'b0;
  logic resetn;
  logic [N-1:0] s_tvalid, s_tready, s_tlast;
  logic [N*DW-1:0] s_tdata;
  logic [N*BW-1:0] s_tkeep, s_tstrb;
  logic [N*UW-1:0] s_tuser;
  logic m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [BW-1:0] m_tkeep, m_tstrb;
  logic [UW-1:0] m_tuser;
  logic [1:0] m_tid;
  logic [15:0] pkt_count;
  logic dbg_state;

  axi_stream_rr_arbiter #(.num_sources(N), .byte_width(BW), .user_width(UW)) dut (
    .clk(clk), .resetn(resetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tstrb(s_tstrb), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tstrb(m_tstrb), .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tid(m_tid),
    .pkt_count(pkt_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // source BFM state and scoreboard
  logic [BEAT_W-1:0] src_q[N][$];
  int gap_q[N][$];
  logic [BEAT_W-1:0] exp_q[N][$];
  logic pres[N];
  int gap_left[N];
  int rem_pkts[N];
  logic src_mid[N];
  int model_ptr, in_pkt, out_beats;
  logic [15:0] model_cnt;
  int ord_q[$];
  int n_checks, n_errors;
  int tr_mode;
  logic tr_val;
  logic prev_stall, prev_acc, prev_acc_last;
  logic [BEAT_W+1:0] prev_out, prev_acc_beat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BEAT_W+1:0] out_word();
    return {m_tid, m_tuser, m_tlast, m_tstrb, m_tkeep, m_tdata};
  endfunction

  function automatic int next_src();
    for (int k = 0; k < N; k++) begin
      if (rem_pkts[(model_ptr + k) % N] > 0) return (model_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int outstanding();
    int s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size() + exp_q[i].size();
    return s;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete(); gap_q[i].delete(); exp_q[i].delete();
      pres[i] = 1'b0; gap_left[i] = 0; rem_pkts[i] = 0; src_mid[i] = 1'b0;
    end
    model_ptr = 0; in_pkt = -1; model_cnt = '0; ord_q.delete();
    prev_stall = 1'b0; prev_acc = 1'b0; prev_acc_last = 1'b0;
  endtask

  // driver: queue one packet; gap1 < 0 gives random gaps on non-first beats
  task automatic enq(input int src, input int len, input int gap1);
    logic [BEAT_W-1:0] b;
    logic [BW-1:0] k;
    if (src_q[src].size() == 0) gap_left[src] = 0;
    for (int j = 0; j < len; j++) begin
      k = BW'($urandom);
      b = {UW'($urandom), (j == len - 1), k & BW'($urandom), k, DW'($urandom)};
      src_q[src].push_back(b);
      if (j == 0) gap_q[src].push_back(0);
      else if (gap1 < 0) gap_q[src].push_back(int'($urandom_range(0, 2)));
      else gap_q[src].push_back((j == 1) ? gap1 : 0);
    end
    rem_pkts[src]++;
  endtask

  // one clock: drive at negedge, sample #1 later, check, and record handshakes
  task automatic cycle();
    logic [BEAT_W-1:0] b;
    logic [BEAT_W+1:0] ow;
    int t, t_exp;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && src_q[i].size() > 0) begin
        if (gap_left[i] > 0) gap_left[i]--;
        else pres[i] = 1'b1;
      end
      s_tvalid[i] = pres[i];
      b = pres[i] ? src_q[i][0] : BEAT_W'({$urandom, $urandom});
      s_tdata[i*DW +: DW] = b[DW-1:0];
      s_tkeep[i*BW +: BW] = b[DW +: BW];
      s_tstrb[i*BW +: BW] = b[DW+BW +: BW];
      s_tlast[i] = b[LAST_B];
      s_tuser[i*UW +: UW] = b[LAST_B+1 +: UW];
    end
    case (tr_mode)
      0: m_tready = 1'b1;
      1: m_tready = ($urandom_range(0, 9) < 7);
      default: m_tready = tr_val;
    endcase
    #1;
    ow = out_word();
    check("pkt_count", pkt_count, model_cnt);
    check("s_tready_onehot0", $onehot0(s_tready), 1);
    if (m_tvalid && !m_tready) check("s_tready_stall", s_tready, 0);
    if (prev_stall) check("m_hold", ow, prev_out);
    if (prev_acc) begin
      check("m_tvalid_latency", m_tvalid, 1);
      check("m_beat_latency", ow, prev_acc_beat);
    end
    if (prev_acc_last) check("bubble", s_tready, 0);
    for (int i = 0; i < N; i++) begin
      if (src_mid[i]) check("lock_other", s_tready & ~(N'(1) << i), 0);
    end
    // output handshake against the packet-level model
    if (m_tvalid && m_tready) begin
      t = int'(m_tid);
      if (in_pkt < 0) begin
        t_exp = next_src();
        check("arb_order", m_tid, t_exp);
        ord_q.push_back(t);
        if (rem_pkts[t] > 0) rem_pkts[t]--;
        in_pkt = t;
      end else begin
        check("no_interleave", m_tid, in_pkt);
      end
      if (exp_q[t].size() == 0) begin
        check("beat_expected", 0, 1);
      end else begin
        b = exp_q[t].pop_front();
        check("payload", ow[BEAT_W-1:0], b);
      end
      if (m_tlast) begin
        model_ptr = (t + 1) % N;
        in_pkt = -1;
        model_cnt++;
      end
      out_beats++;
    end
    // source handshakes
    prev_acc = 1'b0;
    prev_acc_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (s_tvalid[i] && s_tready[i]) begin
        b = src_q[i].pop_front();
        void'(gap_q[i].pop_front());
        exp_q[i].push_back(b);
        pres[i] = 1'b0;
        prev_acc = 1'b1;
        prev_acc_beat = {2'(i), b};
        prev_acc_last = b[LAST_B];
        src_mid[i] = !b[LAST_B];
        gap_left[i] = (gap_q[i].size() > 0) ? gap_q[i][0] : 0;
      end
    end
    prev_stall = m_tvalid && !m_tready;
    prev_out = ow;
  endtask

  task automatic drain(input string tag, input int budget);
    int c = 0;
    while (outstanding() > 0 && c < budget) begin
      cycle();
      c++;
    end
    check({tag, "_drain"}, outstanding(), 0);
    cycle();
    cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    s_tvalid = '0;
    m_tready = 1'b0;
    clear_model();
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_payload", out_word(), 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int c, start;
    n_checks = 0; n_errors = 0; out_beats = 0;
    tr_mode = 0; tr_val = 1'b1;
    resetn = 1'b1;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tstrb = '0; s_tlast = '0; s_tuser = '0;
    m_tready = 1'b0;
    clear_model();

    // 1: single 3-beat packet from source 2
    do_reset();
    enq(2, 3, 0);
    drain("t1", 50);
    check("t1_pkt_count", pkt_count, 1);
    check("t1_order_len", ord_q.size(), 1);
    check("t1_tid", ord_q[0], 2);
    check("t1_ptr", dut.ptr_q, 3);
    check("t1_idle", dbg_state, 0);

    // 2: all sources with 1-beat packets, strict rotation
    do_reset();
    for (int i = 0; i < N; i++) enq(i, 1, 0);
    enq(0, 1, 0);
    drain("t2", 100);
    check("t2_order_len", ord_q.size(), 5);
    for (int k = 0; k < 5; k++) check("t2_order", ord_q[k], exp_ord[k]);
    check("t2_pkt_count", pkt_count, 5);

    // 3: output stall in the middle of a source-1 packet
    enq(1, 4, 0);
    c = 0;
    while (src_q[1].size() > 2 && c < 50) begin cycle(); c++; end
    check("t3_reach_mid", src_q[1].size(), 2);
    tr_mode = 2; tr_val = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t3_s_tready1", s_tready[1], 0);
    end
    tr_mode = 0;
    drain("t3", 50);
    check("t3_pkt_count", pkt_count, 6);

    // randomized traffic with output backpressure and source gaps
    tr_mode = 1;
    for (int k = 0; k < 16; k++) enq($urandom_range(0, N - 1), $urandom_range(1, 4), -1);
    drain("rand", 3000);
    tr_mode = 0;

    // 5: reset in the middle of a source-2 packet
    enq(2, 3, 0);
    start = out_beats;
    c = 0;
    while (out_beats == start && c < 50) begin cycle(); c++; end
    check("t5_mid_packet", (out_beats > start) && (src_q[2].size() > 0), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("t5_m_tvalid", m_tvalid, 0);
    check("t5_s_tready", s_tready, 0);
    check("t5_pkt_count", pkt_count, 0);
    clear_model();
    s_tvalid = '0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    enq(2, 1, 0);
    enq(0, 1, 0);
    drain("t5", 50);
    check("t5_order_len", ord_q.size(), 2);
    check("t5_first", ord_q[0], 0);
    check("t5_second", ord_q[1], 2);

    // 4: source 0 stalls mid-packet while source 3 waits
    do_reset();
    enq(0, 3, 3);
    enq(3, 1, 0);
    drain("t4", 60);
    check("t4_order_len", ord_q.size(), 2);
    check("t4_first", ord_q[0], 0);
    check("t4_second", ord_q[1], 3);

    // 6: counter wrap from 0xFFFF
    @(negedge clk);
    force dut.pkt_count_d = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_count_d;
    model_cnt = 16'hFFFF;
    #1;
    check("t6_preload", pkt_count, 16'hFFFF);
    enq(1, 2, 0);
    drain("t6", 50);
    check("t6_wrap", pkt_count, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
